class_ctrl: RTL and testbench
=============================

Name: class_ctrl

Overview:
- Upstream sequencer/initiator for gen_class.
- Accepts labelled window hypervectors over a valid/ready stream and buffers them in a small FIFO.
- Issues one entry at a time to gen_class: drives en as a one-cycle pulse, holds window_hv/op/label_train stable, and waits for done.
- Returns predictions on a valid/ready output stream. Training entries complete silently.

Parameters:
DIMENSIONS, 10000, hypervector width in bits (matches gen_class)
FIFO_DEPTH, 4, input buffer entries; power of two, >=2
TIMEOUT, 8192, max cycles to wait for cls_done before aborting an entry; must exceed DIMENSIONS/PAR_BITS of gen_class

Ports:
clk  input  1  clock, rising edge
nrst  input  1  asynchronous active-low reset
in_valid  input  1  input entry valid
in_ready  output  1  FIFO can accept (not full)
in_hv  input  DIMENSIONS  window hypervector
in_op  input  1  0=train, 1=predict
in_label  input  1  training label (0 nonseizure, 1 seizure); ignored when in_op=1
cls_en  output  1  one-cycle start pulse to gen_class en
cls_hv  output  DIMENSIONS  to gen_class window_hv
cls_op  output  1  to gen_class op
cls_label_train  output  1  to gen_class label_train
cls_done  input  1  gen_class done
cls_label_predict  input  1  gen_class label_predict
out_valid  output  1  prediction valid
out_ready  input  1  downstream accepts prediction
out_label  output  1  predicted label
busy  output  1  high when state != IDLE or FIFO non-empty
err_timeout  output  1  sticky; set on any timeout
fifo_count  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset (nrst=0, async): FIFO empty, fifo_count=0, state=IDLE. All outputs 0 except in_ready=1. cls_hv=0, err_timeout=0. Reset mid-transaction discards all entries and any pending prediction.
- FIFO:
  - Push when in_valid && in_ready. Stores {in_hv, in_op, in_label}.
  - in_ready = (fifo_count != FIFO_DEPTH).
  - Pop occurs only at entry completion (see below).
  - Push and pop in the same cycle leave the count unchanged. This is legal even when full, but in_ready is still low when full, so no push occurs in that case.
  - Read/write pointers wrap modulo FIFO_DEPTH.
- FSM states IDLE, ISSUE, WAIT, RESP:
  - IDLE: if fifo_count != 0, latch head into cls_hv/cls_op/cls_label_train and go to ISSUE next cycle. Minimum latency from push into an empty FIFO to cls_en high is 2 cycles.
  - ISSUE: cls_en=1 for exactly this cycle; go to WAIT. The timeout counter clears to 0.
  - WAIT: cls_en=0 and the counter increments each cycle. cls_hv/op/label remain stable from ISSUE until the entry completes.
    - cls_done=1 with cls_op=1: capture cls_label_predict into out_label; go to RESP.
    - cls_done=1 with cls_op=0: pop; go to IDLE.
    - Counter reaches TIMEOUT-1 without done: set err_timeout, pop, go to IDLE, no output.
  - RESP: out_valid=1 and out_label is held. On out_ready=1, pop, drop out_valid next cycle, go to IDLE.
- Edge cases:
  - cls_done is ignored outside WAIT.
  - out_valid must not drop or change without out_ready.
  - Back-to-back entries have at least 1 IDLE cycle between completion and the next ISSUE.
  - err_timeout clears only on reset.
  - busy=1 whenever state != IDLE or fifo_count != 0.

Test Plan:
- Reset then idle: nrst low -> in_ready=1, cls_en=0, out_valid=0, fifo_count=0, err_timeout=0. Assert nrst=0 mid-WAIT -> same values immediately (async).
- Single train: push hv=6'b000010, op=0, label=0 with DIMENSIONS=6; responder asserts done 3 cycles after en -> cls_en pulses once, 2 cycles after push. cls_hv=000010 is held until done, out_valid never rises, fifo_count returns to 0.
- Single predict: push hv=6'b111100, op=1; responder returns done with label_predict=1 -> out_valid=1, out_label=1. Hold out_ready=0 for 5 cycles -> value stable. out_ready=1 -> out_valid=0 next cycle, busy=0.
- FIFO full/wrap: push 6 entries back-to-back with FIFO_DEPTH=4 and a slow responder (10-cycle done) -> in_ready drops after 4 accepted. Entries are issued to cls_hv in push order, including after pointer wrap. fifo_count never exceeds 4.
- Simultaneous push/pop: push while an entry completes with the FIFO at 3 -> count stays 3 and no entry is lost or duplicated.
- Timeout: TIMEOUT=16, responder never asserts done -> err_timeout=1 sixteen cycles after cls_en, entry popped, next entry issued. A later done pulse in IDLE is ignored.

Source files
------------

// File: rtl/class_ctrl.sv
// ---------------------------------------------------------------------------
// class_ctrl
//   Upstream sequencer for gen_class. Labelled window hypervectors arrive on a
//   valid/ready stream and are buffered in a small FIFO. Entries are issued to
//   gen_class one at a time: a one-cycle cls_en pulse, with cls_hv / cls_op /
//   cls_label_train held stable until the entry completes. Predict entries
//   return their label on a valid/ready output stream. Train entries complete
//   silently. An entry that does not see cls_done in time is aborted and the
//   sticky err_timeout flag is raised.
//
// Ports
//   clk, nrst          rising-edge clock, asynchronous active-low reset
//   in_valid/in_ready  input handshake (in_ready = FIFO not full)
//   in_hv/op/label     entry payload (op: 0=train, 1=predict)
//   cls_en             one-cycle start pulse to gen_class
//   cls_hv/op/label_train  payload presented to gen_class
//   cls_done           gen_class completion (honoured only while waiting)
//   cls_label_predict  gen_class prediction, captured on done
//   out_valid/ready    prediction handshake, out_label = predicted label
//   busy               FSM not idle or FIFO not empty
//   err_timeout        sticky timeout flag, cleared only by reset
//   fifo_count         current FIFO occupancy (includes the in-flight entry)
// ---------------------------------------------------------------------------
module class_ctrl #(
  parameter int unsigned DIMENSIONS = 10000,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned TIMEOUT    = 8192
) (
  input  logic                          clk,
  input  logic                          nrst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [DIMENSIONS-1:0]         in_hv,
  input  logic                          in_op,
  input  logic                          in_label,
  output logic                          cls_en,
  output logic [DIMENSIONS-1:0]         cls_hv,
  output logic                          cls_op,
  output logic                          cls_label_train,
  input  logic                          cls_done,
  input  logic                          cls_label_predict,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          out_label,
  output logic                          busy,
  output logic                          err_timeout,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned TW = $clog2(TIMEOUT);
  localparam int unsigned EW = DIMENSIONS + 2;

  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);
  localparam logic [TW-1:0] TMR_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RESP
  } state_t;

  state_t         state;

  // FIFO storage: entry = {hv, op, label}
  logic [EW-1:0]  mem [FIFO_DEPTH];
  logic [PW-1:0]  wr_ptr;
  logic [PW-1:0]  rd_ptr;
  logic [CW-1:0]  count;
  logic [EW-1:0]  head;

  logic [TW-1:0]  tmr;

  logic           push;
  logic           pop;
  logic           done_ev;
  logic           expire;

  // -------------------------------------------------------------------------
  // Handshake / completion decode
  // -------------------------------------------------------------------------
  always_comb begin
    head    = mem[rd_ptr];
    push    = in_valid && in_ready;
    done_ev = (state == ST_WAIT) && cls_done;
    expire  = (state == ST_WAIT) && !cls_done && (tmr == TMR_LAST);
    // The head entry stays in the FIFO while in flight; it leaves only once
    // its work is fully finished (train done, timeout, or prediction taken).
    pop     = (done_ev && !cls_op) || expire || ((state == ST_RESP) && out_ready);
  end

  assign in_ready   = (count != FULL_CNT);
  assign busy       = (state != ST_IDLE) || (count != '0);
  assign fifo_count = count;

  // -------------------------------------------------------------------------
  // FIFO pointers and occupancy. FIFO_DEPTH is a power of two, so the
  // pointers wrap modulo the depth by natural overflow.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      unique case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {in_hv, in_op, in_label};
    end
  end

  // -------------------------------------------------------------------------
  // Issue FSM with registered outputs
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state           <= ST_IDLE;
      cls_en          <= 1'b0;
      cls_hv          <= '0;
      cls_op          <= 1'b0;
      cls_label_train <= 1'b0;
      out_valid       <= 1'b0;
      out_label       <= 1'b0;
      err_timeout     <= 1'b0;
      tmr             <= '0;
    end else begin
      cls_en <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (count != '0) begin
            {cls_hv, cls_op, cls_label_train} <= head;
            cls_en <= 1'b1;
            tmr    <= '0;
            state  <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          // Timer counts cycles since the cls_en pulse, so an abort becomes
          // visible exactly TIMEOUT cycles after the pulse.
          tmr   <= tmr + TW'(1);
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (cls_done) begin
            if (cls_op) begin
              out_label <= cls_label_predict;
              out_valid <= 1'b1;
              state     <= ST_RESP;
            end else begin
              state <= ST_IDLE;
            end
          end else if (tmr == TMR_LAST) begin
            err_timeout <= 1'b1;
            state       <= ST_IDLE;
          end else begin
            tmr <= tmr + TW'(1);
          end
        end
        ST_RESP: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_class_ctrl.sv
// ---------------------------------------------------------------------------
// tb_class_ctrl
//   Directed bench for class_ctrl with DIMENSIONS=6, FIFO_DEPTH=4, TIMEOUT=16.
//   A simple gen_class responder lives in the step task: it logs every issued
//   entry and returns done a programmable number of cycles after cls_en.
// ---------------------------------------------------------------------------
module tb_class_ctrl;

  localparam int unsigned D  = 6;
  localparam int unsigned FD = 4;
  localparam int unsigned TO = 16;

  logic         clk = 1'b0;
  logic         nrst = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [D-1:0] in_hv = '0;
  logic         in_op = 1'b0;
  logic         in_label = 1'b0;
  logic         cls_en;
  logic [D-1:0] cls_hv;
  logic         cls_op;
  logic         cls_label_train;
  logic         cls_done = 1'b0;
  logic         cls_label_predict = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic         out_label;
  logic         busy;
  logic         err_timeout;
  logic [2:0]   fifo_count;

  int n_tests = 0;
  int n_fail  = 0;

  // responder / observation state
  bit           resp_on    = 1'b0;
  int           resp_delay = 3;
  logic         resp_label = 1'b0;
  bit           pend       = 1'b0;
  int           rcnt       = 0;
  int           en_count   = 0;
  bit           saw_valid  = 1'b0;
  int           max_count  = 0;
  logic [D:0]   issued [$];

  logic [D-1:0] hv_tab [6] = '{6'h11, 6'h22, 6'h33, 6'h04, 6'h25, 6'h36};

  class_ctrl #(
    .DIMENSIONS (D),
    .FIFO_DEPTH (FD),
    .TIMEOUT    (TO)
  ) dut (
    .clk               (clk),
    .nrst              (nrst),
    .in_valid          (in_valid),
    .in_ready          (in_ready),
    .in_hv             (in_hv),
    .in_op             (in_op),
    .in_label          (in_label),
    .cls_en            (cls_en),
    .cls_hv            (cls_hv),
    .cls_op            (cls_op),
    .cls_label_train   (cls_label_train),
    .cls_done          (cls_done),
    .cls_label_predict (cls_label_predict),
    .out_valid         (out_valid),
    .out_ready         (out_ready),
    .out_label         (out_label),
    .busy              (busy),
    .err_timeout       (err_timeout),
    .fifo_count        (fifo_count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Advance to the next falling edge and run the responder model there.
  task automatic step();
    @(negedge clk);
    cls_done = 1'b0;
    if (out_valid) saw_valid = 1'b1;
    if (int'(fifo_count) > max_count) max_count = int'(fifo_count);
    if (cls_en) begin
      en_count++;
      issued.push_back({cls_hv, cls_label_train});
      if (resp_on) begin
        pend = 1'b1;
        rcnt = resp_delay;
      end
    end else if (pend) begin
      rcnt--;
      if (rcnt == 0) begin
        cls_done          = 1'b1;
        cls_label_predict = resp_label;
        pend              = 1'b0;
      end
    end
  endtask

  task automatic clear_obs();
    en_count  = 0;
    saw_valid = 1'b0;
    max_count = 0;
    issued.delete();
  endtask

  task automatic test_reset();
    nrst = 1'b0; in_valid = 1'b0; out_ready = 1'b0; cls_done = 1'b0; pend = 1'b0;
    repeat (2) @(negedge clk);
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready: got %b want 1", in_ready); end
    n_tests++; if (cls_en !== 1'b0) begin n_fail++; $display("FAIL rst_cls_en: got %b want 0", cls_en); end
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
    n_tests++; if (fifo_count !== 3'd0) begin n_fail++; $display("FAIL rst_fifo_count: got %0d want 0", fifo_count); end
    n_tests++; if (err_timeout !== 1'b0) begin n_fail++; $display("FAIL rst_err: got %b want 0", err_timeout); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", busy); end
    n_tests++; if (cls_hv !== 6'b0) begin n_fail++; $display("FAIL rst_cls_hv: got %b want 000000", cls_hv); end
    nrst = 1'b1;
    step();
    step();
  endtask

  task automatic test_single_train();
    clear_obs();
    resp_on = 1'b1; resp_delay = 3; resp_label = 1'b0;
    in_valid = 1'b1; in_hv = 6'b000010; in_op = 1'b0; in_label = 1'b0;
    step();
    in_valid = 1'b0;
    n_tests++; if (cls_en !== 1'b0 || fifo_count !== 3'd1) begin n_fail++; $display("FAIL train_c1: got en=%b cnt=%0d want en=0 cnt=1", cls_en, fifo_count); end
    step();
    n_tests++; if (cls_en !== 1'b1) begin n_fail++; $display("FAIL train_en_latency: got %b want 1", cls_en); end
    n_tests++; if (cls_hv !== 6'b000010 || cls_op !== 1'b0 || cls_label_train !== 1'b0) begin n_fail++; $display("FAIL train_payload: got hv=%b op=%b lbl=%b want 000010/0/0", cls_hv, cls_op, cls_label_train); end
    for (int i = 0; i < 3; i++) begin
      step();
      n_tests++; if (cls_en !== 1'b0 || cls_hv !== 6'b000010 || fifo_count !== 3'd1) begin n_fail++; $display("FAIL train_hold%0d: got en=%b hv=%b cnt=%0d want 0/000010/1", i, cls_en, cls_hv, fifo_count); end
    end
    step();
    n_tests++; if (fifo_count !== 3'd0 || busy !== 1'b0) begin n_fail++; $display("FAIL train_done: got cnt=%0d busy=%b want 0/0", fifo_count, busy); end
    repeat (3) step();
    n_tests++; if (en_count != 1) begin n_fail++; $display("FAIL train_en_pulses: got %0d want 1", en_count); end
    n_tests++; if (saw_valid !== 1'b0) begin n_fail++; $display("FAIL train_no_out: got out_valid seen=%b want 0", saw_valid); end
  endtask

  task automatic test_single_predict();
    clear_obs();
    resp_on = 1'b1; resp_delay = 3; resp_label = 1'b1;
    in_valid = 1'b1; in_hv = 6'b111100; in_op = 1'b1; in_label = 1'b0;
    step();
    in_valid = 1'b0;
    step();
    n_tests++; if (cls_en !== 1'b1 || cls_op !== 1'b1 || cls_hv !== 6'b111100) begin n_fail++; $display("FAIL pred_issue: got en=%b op=%b hv=%b want 1/1/111100", cls_en, cls_op, cls_hv); end
    repeat (3) step();
    step();
    n_tests++; if (out_valid !== 1'b1 || out_label !== 1'b1) begin n_fail++; $display("FAIL pred_out: got v=%b l=%b want 1/1", out_valid, out_label); end
    n_tests++; if (fifo_count !== 3'd1 || busy !== 1'b1) begin n_fail++; $display("FAIL pred_resp_cnt: got cnt=%0d busy=%b want 1/1", fifo_count, busy); end
    cls_label_predict = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      n_tests++; if (out_valid !== 1'b1 || out_label !== 1'b1) begin n_fail++; $display("FAIL pred_hold%0d: got v=%b l=%b want 1/1", i, out_valid, out_label); end
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    n_tests++; if (out_valid !== 1'b0 || busy !== 1'b0 || fifo_count !== 3'd0) begin n_fail++; $display("FAIL pred_accept: got v=%b busy=%b cnt=%0d want 0/0/0", out_valid, busy, fifo_count); end
  endtask

  task automatic test_fifo_full_wrap();
    int k;
    int guard;
    logic rdy;
    logic [D:0] exp_e;
    clear_obs();
    resp_on = 1'b1; resp_delay = 10; resp_label = 1'b0;
    k = 0;
    guard = 0;
    while (k < 6 && guard < 200) begin
      in_valid = 1'b1; in_hv = hv_tab[k]; in_op = 1'b0; in_label = 1'(k & 1);
      rdy = in_ready;
      step();
      if (rdy) begin
        k++;
        if (k == 4) begin
          n_tests++; if (in_ready !== 1'b0 || fifo_count !== 3'd4) begin n_fail++; $display("FAIL full_ready: got rdy=%b cnt=%0d want 0/4", in_ready, fifo_count); end
        end
      end
      guard++;
    end
    in_valid = 1'b0;
    n_tests++; if (k != 6) begin n_fail++; $display("FAIL full_accepted: got %0d want 6", k); end
    guard = 0;
    while ((fifo_count !== 3'd0 || busy !== 1'b0) && guard < 300) begin
      step();
      guard++;
    end
    n_tests++; if (guard >= 300) begin n_fail++; $display("FAIL full_drain: got busy after %0d cycles want idle", guard); end
    n_tests++; if (issued.size() != 6) begin n_fail++; $display("FAIL full_issue_count: got %0d want 6", issued.size()); end
    for (int i = 0; i < 6; i++) begin
      exp_e = {hv_tab[i], 1'(i & 1)};
      n_tests++; if (i >= issued.size() || issued[i] !== exp_e) begin n_fail++; $display("FAIL full_order%0d: got %b want %b", i, (i < issued.size()) ? issued[i] : 7'bx, exp_e); end
    end
    n_tests++; if (max_count > 4) begin n_fail++; $display("FAIL full_max_count: got %0d want <=4", max_count); end
    n_tests++; if (saw_valid !== 1'b0) begin n_fail++; $display("FAIL full_no_out: got %b want 0", saw_valid); end
  endtask

  task automatic test_push_pop_same_cycle();
    int guard;
    logic [D:0] exp_e;
    clear_obs();
    resp_on = 1'b1; resp_delay = 10; resp_label = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_hv = hv_tab[i + 2]; in_op = 1'b0; in_label = 1'b1;
      step();
    end
    in_valid = 1'b0;
    n_tests++; if (fifo_count !== 3'd3) begin n_fail++; $display("FAIL pp_pre: got %0d want 3", fifo_count); end
    guard = 0;
    while (cls_done !== 1'b1 && guard < 50) begin
      step();
      guard++;
    end
    n_tests++; if (guard >= 50) begin n_fail++; $display("FAIL pp_done_wait: got no done want done"); end
    in_valid = 1'b1; in_hv = 6'h3f; in_op = 1'b0; in_label = 1'b1;
    step();
    in_valid = 1'b0;
    n_tests++; if (fifo_count !== 3'd3) begin n_fail++; $display("FAIL pp_count: got %0d want 3", fifo_count); end
    guard = 0;
    while ((fifo_count !== 3'd0 || busy !== 1'b0) && guard < 200) begin
      step();
      guard++;
    end
    n_tests++; if (issued.size() != 4) begin n_fail++; $display("FAIL pp_issue_count: got %0d want 4", issued.size()); end
    for (int i = 0; i < 4; i++) begin
      exp_e = (i < 3) ? {hv_tab[i + 2], 1'b1} : {6'h3f, 1'b1};
      n_tests++; if (i >= issued.size() || issued[i] !== exp_e) begin n_fail++; $display("FAIL pp_order%0d: got %b want %b", i, (i < issued.size()) ? issued[i] : 7'bx, exp_e); end
    end
  endtask

  task automatic test_timeout();
    clear_obs();
    resp_on = 1'b0;
    in_valid = 1'b1; in_hv = 6'h2a; in_op = 1'b0; in_label = 1'b0;
    step();
    in_hv = 6'h15; in_op = 1'b1;
    step();
    in_valid = 1'b0;
    n_tests++; if (cls_en !== 1'b1 || cls_hv !== 6'h2a) begin n_fail++; $display("FAIL to_issue_x: got en=%b hv=%h want 1/2a", cls_en, cls_hv); end
    for (int i = 1; i <= 15; i++) begin
      step();
      n_tests++; if (err_timeout !== 1'b0) begin n_fail++; $display("FAIL to_early%0d: got %b want 0", i, err_timeout); end
    end
    step();
    n_tests++; if (err_timeout !== 1'b1) begin n_fail++; $display("FAIL to_set: got %b want 1", err_timeout); end
    n_tests++; if (fifo_count !== 3'd1 || cls_en !== 1'b0) begin n_fail++; $display("FAIL to_pop: got cnt=%0d en=%b want 1/0", fifo_count, cls_en); end
    cls_done = 1'b1; cls_label_predict = 1'b1;
    step();
    n_tests++; if (cls_en !== 1'b1 || cls_hv !== 6'h15 || cls_op !== 1'b1) begin n_fail++; $display("FAIL to_next: got en=%b hv=%h op=%b want 1/15/1", cls_en, cls_hv, cls_op); end
    n_tests++; if (fifo_count !== 3'd1 || out_valid !== 1'b0) begin n_fail++; $display("FAIL to_idle_done: got cnt=%0d v=%b want 1/0", fifo_count, out_valid); end
    repeat (16) step();
    n_tests++; if (fifo_count !== 3'd0 || busy !== 1'b0 || err_timeout !== 1'b1) begin n_fail++; $display("FAIL to_second: got cnt=%0d busy=%b err=%b want 0/0/1", fifo_count, busy, err_timeout); end
    cls_done = 1'b1; cls_label_predict = 1'b1;
    step();
    n_tests++; if (out_valid !== 1'b0 || busy !== 1'b0 || cls_en !== 1'b0) begin n_fail++; $display("FAIL to_stray_done: got v=%b busy=%b en=%b want 0/0/0", out_valid, busy, cls_en); end
    n_tests++; if (en_count != 2 || saw_valid !== 1'b0) begin n_fail++; $display("FAIL to_summary: got en=%0d seen_v=%b want 2/0", en_count, saw_valid); end
  endtask

  task automatic test_reset_mid_wait();
    resp_on = 1'b0;
    in_valid = 1'b1; in_hv = 6'h0f; in_op = 1'b1; in_label = 1'b0;
    step();
    in_valid = 1'b0;
    repeat (4) step();
    n_tests++; if (busy !== 1'b1 || err_timeout !== 1'b1 || cls_hv !== 6'h0f) begin n_fail++; $display("FAIL mid_pre: got busy=%b err=%b hv=%h want 1/1/0f", busy, err_timeout, cls_hv); end
    nrst = 1'b0;
    #1;
    n_tests++; if (in_ready !== 1'b1 || cls_en !== 1'b0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_rst_hs: got rdy=%b en=%b v=%b want 1/0/0", in_ready, cls_en, out_valid); end
    n_tests++; if (fifo_count !== 3'd0 || err_timeout !== 1'b0 || busy !== 1'b0 || cls_hv !== 6'h00) begin n_fail++; $display("FAIL mid_rst_state: got cnt=%0d err=%b busy=%b hv=%h want 0/0/0/00", fifo_count, err_timeout, busy, cls_hv); end
    pend = 1'b0;
    step();
    nrst = 1'b1;
    step();
  endtask

  initial begin
    test_reset();
    test_single_train();
    test_single_predict();
    test_fifo_full_wrap();
    test_push_pop_same_cycle();
    test_timeout();
    test_reset_mid_wait();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
